// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of a 5-stage MIPS pipeline.
// Holds the PC, selects the next PC (redirect / hold / sequential), drives the
// instruction-memory address and owns the IF/ID pipeline register. Hazard-unit
// controls stall or squash fetch; redirects resolved in ID load a new PC.
// Two saturating counters record how often IF/ID was held or flushed.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_disable_i,
    input  logic             ifid_disable_i,
    input  logic             flush_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jmp_i,
    input  logic [31:0]      jmp_target_i,
    input  logic             topc_i,
    input  logic [31:0]      topc_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      instr_IFID_o,
    output logic [31:0]      pc_plus4_IFID_o,
    output logic             valid_IFID_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Architectural state
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc_plus4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Next-state / helper nets
    logic             w_redirect;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_pc_next;
    logic             w_stall_evt;
    logic             w_stall_sat;
    logic             w_flush_sat;

    // Any resolved control transfer from ID redirects fetch.
    assign w_redirect  = topc_i | jmp_i | branch_taken_i;

    // Sequential successor; 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
    assign w_pc_plus4  = r_pc + 32'd4;

    // IF/ID hold only counts when it is not overridden by a flush.
    assign w_stall_evt = ifid_disable_i & ~flush_i;
    assign w_stall_sat = &r_stall_cnt;
    assign w_flush_sat = &r_flush_cnt;

    // Redirect target select: jr beats jump beats branch; targets are word aligned.
    always_comb begin
        w_target = branch_target_i;
        if (topc_i) begin
            w_target = topc_target_i;
        end else if (jmp_i) begin
            w_target = jmp_target_i;
        end
        w_target[1:0] = 2'b00;
    end

    // Next PC: a redirect overrides a PC hold, otherwise hold or advance.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (pc_disable_i) begin
            w_pc_next = r_pc;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID register: flush inserts a bubble, hold re-presents the same word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (flush_i) begin
            r_instr    <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (!ifid_disable_i) begin
            r_instr    <= imem_data_i;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    // Saturating debug counters for hold and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && !w_stall_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush_i && !w_flush_sat) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // The memory address comes straight from the PC register, never from redirect inputs.
    assign imem_addr_o     = r_pc;
    assign instr_IFID_o    = r_instr;
    assign pc_plus4_IFID_o = r_pc_plus4;
    assign valid_IFID_o    = r_valid;
    assign stall_cnt_o     = r_stall_cnt;
    assign flush_cnt_o     = r_flush_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a reference model computes the expected
// post-edge state each cycle, pushes it to a scoreboard queue, and the entry is
// popped and compared once the edge has happened. A second instance with a
// 2-bit counter width exercises counter saturation alongside the first.
module tb_if_fetch_stage;

    localparam logic [31:0] IMEM_XOR = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        pc_disable_i, ifid_disable_i, flush_i;
    logic        branch_taken_i, jmp_i, topc_i;
    logic [31:0] branch_target_i, jmp_target_i, topc_target_i;

    logic [31:0] imem_addr_o, imem_data_i, instr_IFID_o, pc_plus4_IFID_o;
    logic        valid_IFID_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] d2_imem_addr, d2_imem_data, d2_instr, d2_pc4;
    logic        d2_valid;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [1:0]  sc2;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_sc, m_fc;
    logic [1:0]  m_sc2;

    assign imem_data_i  = imem_addr_o ^ IMEM_XOR;
    assign d2_imem_data = d2_imem_addr ^ IMEM_XOR;

    if_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .pc_disable_i(pc_disable_i), .ifid_disable_i(ifid_disable_i), .flush_i(flush_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
        .topc_i(topc_i), .topc_target_i(topc_target_i),
        .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .instr_IFID_o(instr_IFID_o), .pc_plus4_IFID_o(pc_plus4_IFID_o),
        .valid_IFID_o(valid_IFID_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    if_fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .pc_disable_i(pc_disable_i), .ifid_disable_i(ifid_disable_i), .flush_i(flush_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
        .topc_i(topc_i), .topc_target_i(topc_target_i),
        .imem_addr_o(d2_imem_addr), .imem_data_i(d2_imem_data),
        .instr_IFID_o(d2_instr), .pc_plus4_IFID_o(d2_pc4),
        .valid_IFID_o(d2_valid),
        .stall_cnt_o(d2_stall_cnt), .flush_cnt_o(d2_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_ctrl();
        pc_disable_i = 0; ifid_disable_i = 0; flush_i = 0;
        branch_taken_i = 0; jmp_i = 0; topc_i = 0;
        branch_target_i = 0; jmp_target_i = 0; topc_target_i = 0;
    endtask

    // One clock: model the edge, queue the expectation, clock, pop and compare.
    task automatic step(input string tag);
        exp_t        e;
        logic [31:0] tgt;
        logic        redir;
        redir = topc_i | jmp_i | branch_taken_i;
        tgt   = topc_i ? topc_target_i : (jmp_i ? jmp_target_i : branch_target_i);
        tgt   = {tgt[31:2], 2'b00};
        if (reset) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_sc = 0; m_fc = 0; m_sc2 = 0;
        end else begin
            if (flush_i) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
                if (m_fc != 16'hFFFF) m_fc = m_fc + 1;
            end else if (ifid_disable_i) begin
                if (m_sc != 16'hFFFF) m_sc = m_sc + 1;
                if (m_sc2 != 2'd3) m_sc2 = m_sc2 + 1;
            end else begin
                m_instr = m_pc ^ IMEM_XOR; m_pc4 = m_pc + 4; m_valid = 1;
            end
            if (redir) m_pc = tgt;
            else if (!pc_disable_i) m_pc = m_pc + 4;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
        e.sc = m_sc; e.fc = m_fc; e.sc2 = m_sc2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"},    imem_addr_o,     e.pc);
        chk({tag, ".instr"}, instr_IFID_o,    e.instr);
        chk({tag, ".pc4"},   pc_plus4_IFID_o, e.pc4);
        chk({tag, ".valid"}, {31'd0, valid_IFID_o}, {31'd0, e.valid});
        chk({tag, ".scnt"},  {16'd0, stall_cnt_o},  {16'd0, e.sc});
        chk({tag, ".fcnt"},  {16'd0, flush_cnt_o},  {16'd0, e.fc});
        chk({tag, ".scnt2"}, {30'd0, d2_stall_cnt}, {30'd0, e.sc2});
        $display("step %-8s pc=%h instr=%h pc4=%h v=%0d scnt=%0d fcnt=%0d scnt2=%0d",
                 tag, imem_addr_o, instr_IFID_o, pc_plus4_IFID_o, valid_IFID_o,
                 stall_cnt_o, flush_cnt_o, d2_stall_cnt);
    endtask

    initial begin
        logic [1:0] sat_exp [6];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        clear_ctrl();
        reset = 1;
        #1;

        // Reset state
        step("rst");
        chk("rst_pc", imem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, valid_IFID_o}, 32'd0);
        reset = 0;

        // Free-running fetch
        step("free1");
        chk("t1_instr", instr_IFID_o, 32'hA5A5_0000);
        chk("t1_pc4", pc_plus4_IFID_o, 32'h4);
        chk("t1_valid", {31'd0, valid_IFID_o}, 32'd1);
        step("free2");
        chk("t1_pc8", imem_addr_o, 32'h8);

        // Load-use stall at PC=8 for two cycles
        pc_disable_i = 1; ifid_disable_i = 1;
        step("stall1");
        chk("t2_pc_hold", imem_addr_o, 32'h8);
        step("stall2");
        chk("t2_instr_hold", instr_IFID_o, 32'hA5A5_0004);
        chk("t2_scnt", {16'd0, stall_cnt_o}, 32'd2);
        clear_ctrl();
        step("resume");
        chk("t2_resume", instr_IFID_o, 32'hA5A5_0008);
        chk("t2_pcC", imem_addr_o, 32'hC);

        // Taken branch with flush beating hold
        branch_taken_i = 1; branch_target_i = 32'h40; flush_i = 1; ifid_disable_i = 1;
        step("branch");
        chk("t3_pc", imem_addr_o, 32'h40);
        chk("t3_bubble", {31'd0, valid_IFID_o}, 32'd0);
        chk("t3_fcnt", {16'd0, flush_cnt_o}, 32'd1);
        clear_ctrl();
        step("tgt");
        chk("t3_tgt_instr", instr_IFID_o, 32'hA5A5_0040);

        // All redirects at once: jr wins and its target is word aligned
        topc_i = 1; topc_target_i = 32'h103;
        jmp_i = 1; jmp_target_i = 32'h200;
        branch_taken_i = 1; branch_target_i = 32'h300;
        #1;
        chk("t4_no_comb_path", imem_addr_o, 32'h44);
        step("prio");
        chk("t4_pc", imem_addr_o, 32'h100);
        clear_ctrl();

        // Counter saturation on the 2-bit instance
        reset = 1;
        step("rst2");
        reset = 0;
        ifid_disable_i = 1;
        for (int i = 0; i < 6; i++) begin
            step("sat");
            chk("t5_sat", {30'd0, d2_stall_cnt}, {30'd0, sat_exp[i]});
        end

        // Reset during a stall
        pc_disable_i = 1; reset = 1;
        step("rst_stall");
        chk("t6_rst_pc", imem_addr_o, 32'h0);
        chk("t6_rst_scnt", {16'd0, stall_cnt_o}, 32'd0);
        reset = 0;
        clear_ctrl();

        // PC wrap at the top of the address space
        topc_i = 1; topc_target_i = 32'hFFFF_FFFF;
        step("to_top");
        chk("t6_top", imem_addr_o, 32'hFFFF_FFFC);
        clear_ctrl();
        step("wrap");
        chk("t6_wrap_pc", imem_addr_o, 32'h0);
        chk("t6_wrap_instr", instr_IFID_o, 32'h5A5A_FFFC);
        chk("t6_wrap_pc4", pc_plus4_IFID_o, 32'h0);
        reset = 1;
        step("rst_end");
        chk("t6_end_instr", instr_IFID_o, 32'h0);
        chk("t6_end_pc", imem_addr_o, 32'h0);
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
